// File: rtl/condicionador_botoes_pkg.sv
// -----------------------------------------------------------------------------
// condicionador_botoes_pkg
//
// Shared definitions for the score input path of one team:
//   - FSM state encoding of the button conditioner (IDLE/EMIT/WAIT_REL)
//   - point codes carried on somaBTNs, also decoded by the score accumulator
//   - default debounce timing (10 ms at 50 MHz)
//   - priority encoder turning a set of button flags into one point code
// -----------------------------------------------------------------------------
package condicionador_botoes_pkg;

    // Conditioner FSM states. Values are fixed so external observers of the
    // state (and the accumulator documentation) can rely on them.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT     = 2'd1,
        ST_WAIT_REL = 2'd2
    } estado_e;

    // Point codes presented on somaBTNs. PTS_0 is the idle value.
    localparam logic [1:0] PTS_0 = 2'b00;
    localparam logic [1:0] PTS_1 = 2'b01;
    localparam logic [1:0] PTS_2 = 2'b10;
    localparam logic [1:0] PTS_3 = 2'b11;

    // Default debounce window: 500000 cycles = 10 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

    // Index of each input inside the 4-bit conditioned vector.
    localparam int IDX_BTN1  = 0;
    localparam int IDX_BTN2  = 1;
    localparam int IDX_BTN3  = 2;
    localparam int IDX_CHAVE = 3;
    localparam int N_ENTRADAS = 4;

    // Highest pressed button wins: +3 over +2 over +1. An empty set yields
    // PTS_0 so the caller can use the result unconditionally.
    function automatic logic [1:0] codigo_pts(input logic [2:0] botoes);
        logic [1:0] codigo;
        codigo = PTS_0;
        if (botoes[2]) begin
            codigo = PTS_3;
        end else if (botoes[1]) begin
            codigo = PTS_2;
        end else if (botoes[0]) begin
            codigo = PTS_1;
        end
        return codigo;
    endfunction

endpackage

// File: rtl/condicionador_botoes_debouncer_botao.sv
// -----------------------------------------------------------------------------
// condicionador_botoes_debouncer_botao
//
// Conditions one raw board input:
//   1. two-flop synchronizer (metastability),
//   2. polarity normalisation (1 = pressed/asserted afterwards),
//   3. debounce: the debounced level only follows the synchronized value
//      after DEBOUNCE_CYCLES consecutive cycles of disagreement,
//   4. registered rise flag, high for one cycle after the debounced level
//      goes 0 -> 1.
//
// Ports
//   clock    in  1  system clock, rising edge
//   clr      in  1  asynchronous reset, active low
//   raw_i    in  1  raw board input (polarity set by ACTIVE_LOW)
//   level_o  out 1  debounced, normalised level
//   rise_o   out 1  one-cycle pulse, one cycle after level_o rises
// -----------------------------------------------------------------------------
module condicionador_botoes_debouncer_botao #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic clr,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    // A counter that cannot hold DEBOUNCE_CYCLES-1 would never accept a change.
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end

    // Raw level that means "released": the synchronizer resets to it so the
    // normalised value starts at 0 and nothing is seen as a press on reset.
    localparam logic RAW_SOLTO = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             norm;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             prev_q;
    logic             rise_q, rise_d;

    assign norm = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            sync1_q <= RAW_SOLTO;
            sync2_q <= RAW_SOLTO;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // The counter measures how long the synchronized value has disagreed
    // with the accepted level; any agreeing cycle restarts the window, so a
    // glitch shorter than the window never reaches level_q.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (norm == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = norm;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise_d = level_q & ~prev_q;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Input stage of one team's score path. Three raw push buttons (+1, +2, +3)
// and the add/subtract switch are synchronized and debounced; an FSM then
// emits exactly one single-cycle point code per physical press and keeps the
// switch level frozen while a press is in flight, so the score accumulator
// always sees a consistent (code, chaveNP) pair.
//
// Ports
//   clock        in  1  system clock, rising edge
//   clr          in  1  asynchronous reset, active low
//   btn_raw      in  3  raw buttons: [0]=+1, [1]=+2, [2]=+3
//   chaveNP_raw  in  1  raw add/subtract switch (asserted = subtract)
//   somaBTNs     out 2  point code, non-zero one cycle per press
//   chaveNP      out 1  debounced switch, constant while a press is in flight
//   busy         out 1  high in EMIT or WAIT_REL
//
// FSM
//   IDLE     : track the switch; on any debounced button rise latch the
//              highest-value code and go to EMIT.
//   EMIT     : code visible for this cycle only; go to WAIT_REL.
//   WAIT_REL : wait for all three buttons released, then IDLE. Further
//              presses while waiting are ignored (no auto-repeat, no
//              secondary codes).
// -----------------------------------------------------------------------------
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       clr,
    input  logic [2:0] btn_raw,
    input  logic       chaveNP_raw,
    output logic [1:0] somaBTNs,
    output logic       chaveNP,
    output logic       busy
);

    logic [N_ENTRADAS-1:0] raw_vec;
    logic [N_ENTRADAS-1:0] nivel;
    logic [N_ENTRADAS-1:0] subida;

    assign raw_vec = {chaveNP_raw, btn_raw};

    for (genvar i = 0; i < N_ENTRADAS; i++) begin : g_entrada
        condicionador_botoes_debouncer_botao #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW)
        ) u_deb (
            .clock   (clock),
            .clr     (clr),
            .raw_i   (raw_vec[i]),
            .level_o (nivel[i]),
            .rise_o  (subida[i])
        );
    end

    // Only the level of the switch matters; its rise flag has no consumer.
    logic unused_sw_rise;
    assign unused_sw_rise = subida[IDX_CHAVE];

    logic [2:0] btn_nivel;
    logic [2:0] btn_subida;
    assign btn_nivel  = nivel[IDX_BTN3:IDX_BTN1];
    assign btn_subida = subida[IDX_BTN3:IDX_BTN1];

    estado_e    state_q, state_d;
    logic [1:0] soma_q, soma_d;
    logic       chave_q, chave_d;

    // Next state and registered outputs. soma_d defaults to idle so the code
    // can only ever be non-zero for the single cycle spent in EMIT.
    always_comb begin
        state_d = state_q;
        soma_d  = PTS_0;
        chave_d = chave_q;
        unique case (state_q)
            ST_IDLE: begin
                chave_d = nivel[IDX_CHAVE];
                if (|btn_subida) begin
                    soma_d  = codigo_pts(btn_subida);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (btn_nivel == 3'b000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            soma_q  <= PTS_0;
            chave_q <= 1'b0;
        end else begin
            state_q <= state_d;
            soma_q  <= soma_d;
            chave_q <= chave_d;
        end
    end

    assign somaBTNs = soma_q;
    assign chaveNP  = chave_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botoes
//
// Bench for condicionador_botoes with DEBOUNCE_CYCLES=4, active-low inputs.
// A reference model derived from the input history runs alongside the DUT
// and every output is compared on each falling edge; directed sequences and
// a table of press patterns check pulse counts, codes and switch handling.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       clr;
    logic [2:0] btn_raw;
    logic       chaveNP_raw;
    logic [1:0] somaBTNs;
    logic       chaveNP;
    logic       busy;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    condicionador_botoes #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (20),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clock       (clock),
        .clr         (clr),
        .btn_raw     (btn_raw),
        .chaveNP_raw (chaveNP_raw),
        .somaBTNs    (somaBTNs),
        .chaveNP     (chaveNP),
        .busy        (busy)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- reference model ----------------
    // Debounced level of an input flips once the last DEB synchronized
    // samples (raw delayed by two edges) all disagree with it. A press is
    // reported two edges after its debounced rise; then no further press is
    // reported until every button is debounced-released.
    logic [3:0] hist [0:DEB+1];
    logic [3:0] lev, lev1, lev2, nl, rp;
    int         ph;
    int         m_diff;
    logic [1:0] e_soma;
    logic       e_chave, e_busy;

    always @(posedge clock or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i <= DEB + 1; i++) hist[i] = 4'b0000;
            lev = 0; lev1 = 0; lev2 = 0; ph = 0;
            e_soma = 2'b00; e_chave = 1'b0; e_busy = 1'b0;
        end else begin
            for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ~{chaveNP_raw, btn_raw};
            nl = lev;
            for (int b = 0; b < 4; b++) begin
                m_diff = 0;
                for (int j = 0; j < DEB; j++) if (hist[2+j][b] != lev[b]) m_diff++;
                if (m_diff == DEB) nl[b] = ~lev[b];
            end
            rp = lev1 & ~lev2;
            e_soma = 2'b00;
            if (ph == 0) begin
                e_chave = lev[3];
                if (rp[2:0] != 3'b000) begin
                    e_soma = rp[2] ? 2'd3 : (rp[1] ? 2'd2 : 2'd1);
                    ph = 1;
                end
            end else if (ph == 1) begin
                ph = 2;
            end else if (lev[2:0] == 3'b000) begin
                ph = 0;
            end
            lev2 = lev1; lev1 = lev; lev = nl;
            e_busy = (ph != 0);
        end
    end

    // ---------------- scoreboard ----------------
    logic       chk_en = 1'b0;
    logic       sb_en  = 1'b0;
    logic [1:0] exp_q[$];
    int         pulse_cnt = 0;
    int         first_pulse_cyc = -1;
    logic [1:0] last_code = 2'b00;
    logic       last_chave = 1'b0;

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_soma", int'(somaBTNs), int'(e_soma));
            check("model_chave", int'(chaveNP), int'(e_chave));
            check("model_busy", int'(busy), int'(e_busy));
        end
        if (somaBTNs != 2'b00) begin
            pulse_cnt++;
            last_code  = somaBTNs;
            last_chave = chaveNP;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            if (sb_en) begin
                if (exp_q.size() == 0) check("sb_unexpected", int'(somaBTNs), 0);
                else check("sb_code", int'(somaBTNs), int'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] pat;   // pressed buttons, 1 = pressed
        logic       sw;    // switch asserted
        logic [1:0] code;  // expected point code (0 = no pulse)
        logic       chave; // expected chaveNP during the pulse
    } vec_t;

    vec_t tbl [8];
    int   c0;

    initial begin
        tbl[0] = '{3'b001, 1'b0, 2'd1, 1'b0};
        tbl[1] = '{3'b010, 1'b1, 2'd2, 1'b1};
        tbl[2] = '{3'b100, 1'b0, 2'd3, 1'b0};
        tbl[3] = '{3'b011, 1'b1, 2'd2, 1'b1};
        tbl[4] = '{3'b101, 1'b0, 2'd3, 1'b0};
        tbl[5] = '{3'b110, 1'b1, 2'd3, 1'b1};
        tbl[6] = '{3'b111, 1'b0, 2'd3, 1'b0};
        tbl[7] = '{3'b000, 1'b1, 2'd0, 1'b1};

        // 1: async reset with every button held
        clr = 1'b1; btn_raw = 3'b000; chaveNP_raw = 1'b1;
        #2 clr = 1'b0;
        #1;
        check("rst_soma", int'(somaBTNs), 0);
        check("rst_chave", int'(chaveNP), 0);
        check("rst_busy", int'(busy), 0);
        chk_en = 1'b1;
        tick(3);
        clr = 1'b1;
        tick(15);
        check("rst_held_cnt", pulse_cnt, 1);
        check("rst_held_code", int'(last_code), 3);
        btn_raw = 3'b111;
        tick(15);

        // 2: +2 press, latency and width
        pulse_cnt = 0; first_pulse_cyc = -1; c0 = cyc;
        btn_raw[1] = 1'b0;
        tick(20);
        check("p2_cnt", pulse_cnt, 1);
        check("p2_code", int'(last_code), 2);
        check("p2_latency", first_pulse_cyc - c0, DEB + 4);
        btn_raw = 3'b111;
        tick(15);

        // 3: bouncing +1
        pulse_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            btn_raw[0] = 1'b0; tick(2);
            btn_raw[0] = 1'b1; tick(2);
        end
        check("bounce_quiet", pulse_cnt, 0);
        btn_raw[0] = 1'b0;
        tick(15);
        check("bounce_cnt", pulse_cnt, 1);
        check("bounce_code", int'(last_code), 1);
        btn_raw = 3'b111;
        tick(15);

        // 4: +1 and +3 together, then +3 released while +1 held
        pulse_cnt = 0;
        btn_raw = 3'b010;
        tick(12);
        btn_raw = 3'b110;
        tick(15);
        check("simul_cnt", pulse_cnt, 1);
        check("simul_code", int'(last_code), 3);
        check("simul_busy_held", int'(busy), 1);
        btn_raw = 3'b111;
        tick(15);
        check("simul_busy_rel", int'(busy), 0);

        // 5: switch asserted, +3, switch toggled during WAIT_REL
        chaveNP_raw = 1'b0;
        tick(12);
        pulse_cnt = 0;
        btn_raw = 3'b011;
        tick(15);
        check("sw_cnt", pulse_cnt, 1);
        check("sw_code", int'(last_code), 3);
        check("sw_chave_pulse", int'(last_chave), 1);
        chaveNP_raw = 1'b1;
        tick(12);
        check("sw_frozen", int'(chaveNP), 1);
        btn_raw = 3'b111;
        tick(12);
        check("sw_updated", int'(chaveNP), 0);
        check("sw_idle", int'(busy), 0);

        // 6: reset during WAIT_REL with +2 held through it
        pulse_cnt = 0;
        btn_raw = 3'b101;
        tick(12);
        check("rst2_pre_cnt", pulse_cnt, 1);
        check("rst2_pre_busy", int'(busy), 1);
        #2 clr = 1'b0;
        #1;
        check("rst2_soma", int'(somaBTNs), 0);
        check("rst2_busy", int'(busy), 0);
        tick(3);
        pulse_cnt = 0;
        clr = 1'b1;
        tick(15);
        check("rst2_cnt", pulse_cnt, 1);
        check("rst2_code", int'(last_code), 2);
        btn_raw = 3'b111;
        tick(15);

        // table of press patterns
        for (int t = 0; t < 8; t++) begin
            chaveNP_raw = ~tbl[t].sw;
            tick(10);
            pulse_cnt = 0;
            if (tbl[t].code != 2'd0) exp_q.push_back(tbl[t].code);
            sb_en = 1'b1;
            btn_raw = ~tbl[t].pat;
            tick(12);
            check("tbl_cnt", pulse_cnt, (tbl[t].code != 2'd0) ? 1 : 0);
            if (tbl[t].code != 2'd0) begin
                check("tbl_code", int'(last_code), int'(tbl[t].code));
                check("tbl_chave", int'(last_chave), int'(tbl[t].chave));
            end
            btn_raw = 3'b111;
            tick(12);
            sb_en = 1'b0;
            check("tbl_chave_idle", int'(chaveNP), int'(tbl[t].sw));
        end
        check("sb_left", exp_q.size(), 0);

        // random stimulus, checked cycle by cycle against the model
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 2) == 0) btn_raw = 3'b111;
            else btn_raw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) chaveNP_raw = ~chaveNP_raw;
            tick($urandom_range(1, 9));
        end
        btn_raw = 3'b111;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
